reg16_burst_ctrl: RTL and testbench
===================================

Name: reg16_burst_ctrl

Overview:
Burst access sequencer that sits directly upstream of the reg16 16x16 register file and is its only driver.
- Accepts write or read burst commands over a valid/ready interface.
- Streams write beats into reg16, or streams read beats back out of it.
- Generates reg16's we/re/addr/data_in with auto-incrementing, wrapping addresses, and captures data_out.
- Replaces ad-hoc stimulus loops as the access path into reg16.

Parameters:
DATA_W, 16, data width; matches reg16 data_in/data_out.
ADDR_W, 4, address width; 2**ADDR_W entries, wrap modulo 16.
RD_LAT, 1, cycles from rf_re sampled high to rf_data_out valid; range 1..3.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&ready
cmd_write  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_W  start address
cmd_len  input  ADDR_W  beats minus one (0 gives 1 beat, 15 gives 16 beats)
wr_valid  input  1  write beat offered
wr_ready  output  1  write beat accepted when valid&ready
wr_data  input  DATA_W  write beat data
rd_valid  output  1  read beat available
rd_ready  input  1  consumer takes read beat
rd_data  output  DATA_W  read beat data
rd_last  output  1  final beat of the burst, qualified by rd_valid
busy  output  1  burst in progress
rf_we  output  1  to reg16 we
rf_re  output  1  to reg16 re
rf_addr  output  ADDR_W  to reg16 addr
rf_data_in  output  DATA_W  to reg16 data_in
rf_data_out  input  DATA_W  from reg16 data_out

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs are 0, including cmd_ready; the burst in progress is abandoned.
  - reg16 contents are untouched.
  - cmd_ready rises on the first posedge after rst deasserts.
- States: IDLE, WR, RD_REQ, RD_WAIT, RD_HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr_q=cmd_addr and cnt_q=cmd_len, then go to WR (cmd_write=1) or RD_REQ (cmd_write=0). cmd_ready drops the same edge.
- WR:
  - wr_ready=1.
  - Each accepted beat drives, registered, for one cycle: rf_we=1, rf_addr=addr_q, rf_data_in=wr_data.
  - Then addr_q increments mod 16 and cnt_q decrements.
  - If wr_valid=0, no write occurs and there is no address change.
  - Beat with cnt_q==0: go to IDLE after the write.
- RD_REQ: pulse rf_re=1 for one cycle with rf_addr=addr_q, then go to RD_WAIT.
- RD_WAIT:
  - Wait RD_LAT cycles.
  - Capture rf_data_out into rd_data, set rd_valid=1 and rd_last=(cnt_q==0), then go to RD_HOLD.
- RD_HOLD:
  - rd_data, rd_valid and rd_last are held stable until rd_ready=1.
  - On handshake, clear rd_valid, then either go to IDLE (last beat) or increment addr_q, decrement cnt_q and go to RD_REQ.
  - Exactly one read is outstanding at a time. Per-beat throughput is RD_LAT+2 cycles when rd_ready is held high.
- Address wrap: 15+1 gives 0, with no error. Bursts longer than 16 beats are impossible by encoding.
- rf_we and rf_re are never high in the same cycle. Both are 0 in IDLE.
- busy=1 in every state except IDLE.
- New commands are ignored (cmd_ready=0) until the current burst fully completes.
- rf_* outputs are registered, with no combinational path from host inputs to reg16.

Decomposition:
- Shared package reg16_pkg holds:
  - localparams DATA_W=16, ADDR_W=4, REG_DEPTH=16;
  - state encoding constants ST_IDLE, ST_WR, ST_RD_REQ, ST_RD_WAIT, ST_RD_HOLD.
- Sub-module reg16_addr_cnt: address/beat counter with load, step, wrap and last flag.
- The FSM and datapath remain in reg16_burst_ctrl.
- The bench instantiates reg16_burst_ctrl plus reg16.

Test Plan:
1. Reset mid-burst: assert rst during the 3rd beat of a 16-beat write -> all outputs 0 that cycle; cmd_ready=1 one cycle after release; locations beyond the 2nd write are unchanged.
2. Single write/read: write addr=5 len=0 data=16'hA5A5, then read addr=5 len=0 -> one rf_we pulse at addr 5; rd_data=16'hA5A5 with rd_last=1.
3. Wrap burst: write addr=14 len=3 data 1,2,3,4 -> rf_addr sequence 14,15,0,1; read the same burst -> 1,2,3,4 with rd_last only on the 4th beat.
4. Back-pressure: 4-beat read with rd_ready low for 5 cycles on beat 2 -> rd_data stable throughout; no extra rf_re pulse; all beats correct.
5. Write stall: wr_valid gaps of 2 cycles between beats of len=15 full sweep with random data -> exactly 16 rf_we pulses; read-back matches all 16 values.
6. Command during busy: cmd_valid held high during a read burst -> cmd_ready stays 0; the command is accepted on the cycle after the burst returns to IDLE.

Source files
------------

// File: rtl/reg16_pkg.sv
// Shared definitions for the reg16 register file and its burst sequencer.
package reg16_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 4;
    localparam int REG_DEPTH = 16;

    // Sequencer states; IDLE must stay at zero so the reset value is IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_HOLD = 3'd4
    } state_e;

endpackage

// File: rtl/reg16_addr_cnt.sv
// Burst address / beat counter: loads a start address and beat count,
// steps address up (wrapping naturally at 2**ADDR_W) and count down.
module reg16_addr_cnt #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_ld_i,
    input  logic [ADDR_W-1:0] len_ld_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] addr_nxt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next address/count: load has priority over step.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_ld_i;
            cnt_d  = len_ld_i;
        end else if (step_i) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o     = addr_q;
    assign addr_nxt_o = addr_d;
    assign last_o     = (cnt_q == '0);

endmodule

// File: rtl/reg16_burst_ctrl.sv
// Burst sequencer in front of the reg16 register file: accepts write/read
// burst commands and drives reg16 with registered we/re/addr/data_in.
module reg16_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              rf_we,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    import reg16_pkg::*;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rf_we_q, rf_we_d;
    logic              rf_re_q, rf_re_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_in_q, rf_data_in_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        lat_q, lat_d;

    logic              cnt_load, cnt_step, cnt_last;
    logic [ADDR_W-1:0] addr_cur, addr_nxt;

    reg16_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .step_i     (cnt_step),
        .addr_ld_i  (cmd_addr),
        .len_ld_i   (cmd_len),
        .addr_o     (addr_cur),
        .addr_nxt_o (addr_nxt),
        .last_o     (cnt_last)
    );

    // Next-state and next-output logic. rf_re is raised on the edge that
    // enters RD_REQ so the read strobe is high exactly during RD_REQ.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_step     = 1'b0;
        rf_we_d      = 1'b0;
        rf_re_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_in_d = rf_data_in_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        rd_data_d    = rd_data_q;
        lat_d        = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cnt_load = 1'b1;
                    if (cmd_write) begin
                        state_d = ST_WR;
                    end else begin
                        state_d   = ST_RD_REQ;
                        rf_re_d   = 1'b1;
                        rf_addr_d = addr_nxt;
                    end
                end
            end
            ST_WR: begin
                if (wr_valid) begin
                    rf_we_d      = 1'b1;
                    rf_addr_d    = addr_cur;
                    rf_data_in_d = wr_data;
                    cnt_step     = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
                lat_d   = '0;
            end
            ST_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    rd_data_d  = rf_data_out;
                    rd_valid_d = 1'b1;
                    rd_last_d  = cnt_last;
                    state_d    = ST_RD_HOLD;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_step  = 1'b1;
                        state_d   = ST_RD_REQ;
                        rf_re_d   = 1'b1;
                        rf_addr_d = addr_nxt;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset clears every output including cmd_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_re_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_in_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
            lat_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rf_we_q      <= rf_we_d;
            rf_re_q      <= rf_re_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_in_q <= rf_data_in_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_data_q    <= rd_data_d;
            lat_q        <= lat_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign wr_ready   = (state_q == ST_WR);
    assign busy       = (state_q != ST_IDLE);
    assign rf_we      = rf_we_q;
    assign rf_re      = rf_re_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data_in = rf_data_in_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_reg16_burst_ctrl.sv
// Testbench for reg16_burst_ctrl with a behavioural reg16 register file.
module tb_reg16_burst_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 1;

    logic              clk, rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr, cmd_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, rd_ready, rd_last, busy;
    logic [DATA_W-1:0] rd_data;
    logic              rf_we, rf_re;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data_in, rf_data_out;

    logic [DATA_W-1:0] mem     [16];
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] wbuf    [16];
    logic [ADDR_W-1:0] we_addr_log [$];
    logic [DATA_W-1:0] we_data_log [$];
    int vectors, miscompares, re_count, both_count;

    reg16_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .rf_we(rf_we), .rf_re(rf_re), .rf_addr(rf_addr),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reg16 model: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_data_in;
        if (rf_re) rf_data_out <= mem[rf_addr];
    end

    // Bus monitor.
    always @(posedge clk) begin
        if (rf_we) begin
            we_addr_log.push_back(rf_addr);
            we_data_log.push_back(rf_data_in);
        end
        if (rf_re) re_count++;
        if (rf_we && rf_re) both_count++;
    end

    task automatic send_cmd(input bit w, input logic [3:0] a, input int len);
        int t;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 4'(len);
        t = 0;
        while (!cmd_ready && t < 60) begin @(posedge clk); #1; t++; end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%0b want 1 within 60 cycles", cmd_ready);
        end else begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic put_beat(input logic [15:0] d, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        wr_valid = 1'b1; wr_data = d;
        t = 0;
        while (!wr_ready && t < 40) begin @(posedge clk); #1; t++; end
        vectors++;
        if (!wr_ready) begin
            miscompares++;
            $display("FAIL wr_accept: wr_ready=%0b want 1", wr_ready);
        end else begin
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin @(posedge clk); #1; t++; end
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL idle_timeout: busy=%0b want 0", busy);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic write_burst(input logic [3:0] base, input int len, input int gap);
        int start;
        logic [3:0] idx;
        start = we_addr_log.size();
        send_cmd(1'b1, base, len);
        for (int i = 0; i <= len; i++) begin
            put_beat(wbuf[i], (i == 0) ? 0 : gap);
            idx = base + 4'(i);
            ref_mem[idx] = wbuf[i];
        end
        wait_idle();
        vectors++;
        if (we_addr_log.size() - start != len + 1) begin
            miscompares++;
            $display("FAIL we_pulse_count: got %0d want %0d", we_addr_log.size() - start, len + 1);
        end else begin
            for (int i = 0; i <= len; i++) begin
                idx = base + 4'(i);
                vectors++;
                if (we_addr_log[start+i] !== idx || we_data_log[start+i] !== wbuf[i]) begin
                    miscompares++;
                    $display("FAIL we_beat%0d: got addr %0d data %h want addr %0d data %h",
                             i, we_addr_log[start+i], we_data_log[start+i], idx, wbuf[i]);
                end
            end
        end
    endtask

    task automatic read_beats(input logic [3:0] base, input int len, input int stall_beat,
                              input int stall_cyc, input bit chk_cmd);
        int t;
        logic [3:0] idx;
        logic [15:0] exp;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!rd_valid && t < 40) begin
                if (chk_cmd) begin
                    vectors++;
                    if (cmd_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL cmd_ready_busy: got %0b want 0", cmd_ready);
                    end
                end
                @(posedge clk); #1; t++;
            end
            vectors++;
            if (!rd_valid) begin
                miscompares++;
                $display("FAIL rd_valid_timeout: beat %0d rd_valid=%0b want 1", i, rd_valid);
                return;
            end
            idx = base + 4'(i);
            exp = ref_mem[idx];
            vectors++;
            if (rd_data !== exp || rd_last !== (i == len)) begin
                miscompares++;
                $display("FAIL rd_beat%0d: got data %h last %0b want data %h last %0b",
                         i, rd_data, rd_last, exp, (i == len));
            end
            if (i == stall_beat) begin
                for (int k = 0; k < stall_cyc; k++) begin
                    @(posedge clk); #1;
                    vectors++;
                    if (rd_valid !== 1'b1 || rd_data !== exp || cmd_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rd_hold: got valid %0b data %h want valid 1 data %h",
                                 rd_valid, rd_data, exp);
                    end
                end
            end
            rd_ready = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
        end
    endtask

    task automatic read_burst(input logic [3:0] base, input int len, input int stall_beat,
                              input int stall_cyc);
        send_cmd(1'b0, base, len);
        read_beats(base, len, stall_beat, stall_cyc, 1'b0);
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if ({cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, rf_we, rf_re, rf_addr, rf_data_in} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: cmd_ready %0b busy %0b rf_we %0b rf_re %0b want all 0",
                     cmd_ready, busy, rf_we, rf_re);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_ready_pre_edge: got %0b want 0", cmd_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_ready_after_reset: got %0b busy %0b want 1 busy 0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 16'hA5A5;
        write_burst(4'd5, 0, 0);
        read_burst(4'd5, 0, -1, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
        write_burst(4'd14, 3, 0);
        read_burst(4'd14, 3, -1, 0);
    endtask

    task automatic test_write_stall();
        logic [3:0] base;
        base = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
        write_burst(base, 15, 2);
        read_burst(base, 15, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] base;
        logic [3:0] idx;
        base = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) wbuf[i] = ~ref_mem[4'(base + 4'(i))];
        send_cmd(1'b1, base, 15);
        put_beat(wbuf[0], 0);
        put_beat(wbuf[1], 0);
        put_beat(wbuf[2], 0);
        ref_mem[base] = wbuf[0];
        idx = base + 4'd1;
        ref_mem[idx] = wbuf[1];
        rst = 1'b1;
        #1;
        vectors++;
        if ({cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, rf_we, rf_re, rf_addr, rf_data_in} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: busy %0b rf_we %0b wr_ready %0b want all 0",
                     busy, rf_we, wr_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_cmd_ready_low: got %0b want 0", cmd_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_cmd_ready_high: got %0b want 1", cmd_ready);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (mem[i] !== ref_mem[i]) begin
                miscompares++;
                $display("FAIL reset_mid_mem%0d: got %h want %h", i, mem[i], ref_mem[i]);
            end
        end
        read_burst(base, 3, -1, 0);
    endtask

    task automatic test_backpressure();
        logic [3:0] base;
        int re0;
        base = 4'($urandom_range(0, 15));
        re0 = re_count;
        read_burst(base, 3, 1, 5);
        vectors++;
        if (re_count - re0 != 4) begin
            miscompares++;
            $display("FAIL re_pulse_count: got %0d want 4", re_count - re0);
        end
    endtask

    task automatic test_cmd_busy();
        logic [3:0] base, nxt;
        base = 4'($urandom_range(0, 15));
        nxt  = 4'($urandom_range(0, 15));
        send_cmd(1'b0, base, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = nxt; cmd_len = 4'd0;
        read_beats(base, 1, 0, 2, 1'b1);
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_ready_after_burst: got ready %0b busy %0b want 1 0", cmd_ready, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL queued_cmd_accept: got busy %0b ready %0b want 1 0", busy, cmd_ready);
        end
        cmd_valid = 1'b0;
        read_beats(nxt, 0, -1, 0, 1'b0);
        wait_idle();
    endtask

    task automatic test_random();
        logic [3:0] base;
        int len;
        for (int n = 0; n < 6; n++) begin
            base = 4'($urandom_range(0, 15));
            len  = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
            write_burst(base, len, $urandom_range(0, 2));
            read_burst(base, len, $urandom_range(0, len), $urandom_range(0, 3));
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; re_count = 0; both_count = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_write_stall();
        test_reset_mid_burst();
        test_backpressure();
        test_cmd_busy();
        test_random();
        vectors++;
        if (both_count != 0) begin
            miscompares++;
            $display("FAIL we_re_overlap: got %0d cycles want 0", both_count);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
